// File: rtl/ram_bank_pkg.sv
// Shared constants and state encoding for the RAM bank sequencer/arbiter.
package ram_bank_pkg;

  // Geometry of one 1Kx8 RAM chip.
  localparam int RAM_AW = 10;
  localparam int RAM_DW = 8;

  // Sequencer states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_STROBE = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

endpackage

// File: rtl/ram_bank_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A lone request always wins; on a tie the
// requester that was not granted last wins. The history only moves on an
// actual grant (i_grant_en with a non-zero grant).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_grant_en,
  output logic [1:0] o_gnt,
  output logic       o_rr_last
);

  logic r_rr_last;

  // Grant decode from the current requests and the last winner.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_rr_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Remember who won; reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_last <= 1'b1;
    end else if (i_grant_en && (o_gnt != 2'b00)) begin
      r_rr_last <= o_gnt[1];
    end
  end

  assign o_rr_last = r_rr_last;

endmodule

// File: rtl/ram_bank_arbiter.sv
// Shares a bank of NUM_CHIPS 1Kx8 RAM chips between two requesters. A flat
// address is split into chip index (upper bits) and word address (low 10
// bits). Each access runs SETUP, STROBE (active-low chip select held for
// STROBE_CYCLES cycles) and HOLD, so address, data and write enable are
// always stable around both edges of the chip select.
//
// Handshake: a requester raises mX_valid with we/addr/wdata and keeps them
// stable until it sees mX_ready high for one cycle; the command was taken on
// the clock edge that raised ready. Read data returns later as a one-cycle
// mX_rvalid pulse, with mX_rdata held until the next pulse. Writes return
// nothing.
module ram_bank_arbiter
  import ram_bank_pkg::*;
#(
  parameter int NUM_CHIPS     = 4,
  parameter int STROBE_CYCLES = 2,
  localparam int CW = $clog2(NUM_CHIPS),
  localparam int AW = RAM_AW + CW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        m0_valid,
  output logic                        m0_ready,
  input  logic                        m0_we,
  input  logic [AW-1:0]               m0_addr,
  input  logic [RAM_DW-1:0]           m0_wdata,
  output logic                        m0_rvalid,
  output logic [RAM_DW-1:0]           m0_rdata,
  input  logic                        m1_valid,
  output logic                        m1_ready,
  input  logic                        m1_we,
  input  logic [AW-1:0]               m1_addr,
  input  logic [RAM_DW-1:0]           m1_wdata,
  output logic                        m1_rvalid,
  output logic [RAM_DW-1:0]           m1_rdata,
  output logic [RAM_AW-1:0]           mem_addr,
  output logic [RAM_DW-1:0]           mem_wdata,
  output logic                        mem_we,
  output logic [NUM_CHIPS-1:0]        mem_cs_n,
  input  logic [RAM_DW*NUM_CHIPS-1:0] mem_rdata,
  output state_t                      dbg_state
);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_owner;
  logic [CW-1:0]         r_chip;
  logic                  r_we;
  logic [RAM_AW-1:0]     r_addr;
  logic [RAM_DW-1:0]     r_wdata;
  logic [NUM_CHIPS-1:0]  r_cs_n;
  logic                  r_m0_ready;
  logic                  r_m1_ready;
  logic                  r_m0_rvalid;
  logic                  r_m1_rvalid;
  logic [RAM_DW-1:0]     r_m0_rdata;
  logic [RAM_DW-1:0]     r_m1_rdata;

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_rr_last;
  logic                  w_accept;
  logic                  w_sel_we;
  logic [AW-1:0]         w_sel_addr;
  logic [RAM_DW-1:0]     w_sel_wdata;
  logic [NUM_CHIPS-1:0]  w_cs_sel;
  logic [RAM_DW-1:0]     w_rd_slice;

  // Requests only count while the sequencer is free to take a command.
  assign w_req    = (r_state == ST_IDLE) ? {m1_valid, m0_valid} : 2'b00;
  assign w_accept = (w_req != 2'b00);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (w_req),
    .i_grant_en (w_accept),
    .o_gnt      (w_gnt),
    .o_rr_last  (w_rr_last)
  );

  // Command mux toward the winner.
  assign w_sel_we    = w_gnt[1] ? m1_we    : m0_we;
  assign w_sel_addr  = w_gnt[1] ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gnt[1] ? m1_wdata : m0_wdata;

  // One-hot select of the latched chip and its read-data lane.
  assign w_cs_sel   = {{(NUM_CHIPS-1){1'b0}}, 1'b1} << r_chip;
  assign w_rd_slice = mem_rdata[int'(r_chip)*RAM_DW +: RAM_DW];

  // Sequencer: arbitration, command latch, strobe timing and read capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_owner     <= 1'b0;
      r_chip      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cs_n      <= '1;
      r_m0_ready  <= 1'b0;
      r_m1_ready  <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_ready  <= 1'b0;
      r_m1_ready  <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner    <= w_gnt[1];
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr[RAM_AW-1:0];
            r_chip     <= w_sel_addr[AW-1:RAM_AW];
            r_wdata    <= w_sel_wdata;
            r_m0_ready <= w_gnt[0];
            r_m1_ready <= w_gnt[1];
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_cs_n  <= ~w_cs_sel;
          r_cnt   <= 4'(STROBE_CYCLES - 1);
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_cs_n  <= '1;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (!r_we) begin
            if (r_owner) begin
              r_m1_rdata  <= w_rd_slice;
              r_m1_rvalid <= 1'b1;
            end else begin
              r_m0_rdata  <= w_rd_slice;
              r_m0_rvalid <= 1'b1;
            end
          end
          r_we    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cs_n  <= '1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_ready  = r_m0_ready;
  assign m1_ready  = r_m1_ready;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign mem_cs_n  = r_cs_n;
  assign dbg_state = r_state;

  // Arbiter history is internal; only its grants matter here.
  logic w_unused;
  assign w_unused = w_rr_last;

endmodule
